// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch queue: reset PC, PC stride and the occupancy width helper.
package fetch_queue_pkg;

  localparam logic [63:0] FqResetPc = 64'h0;
  localparam int unsigned FqPcInc   = 4;

  // Occupancy must represent 0..depth inclusive.
  function automatic int unsigned fq_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fq_fifo.sv
// Power-of-two circular buffer with first-word fall-through read and a synchronous flush.
module fq_fifo
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic [fq_cnt_w(DEPTH)-1:0]  count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = fq_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  // Guards keep the occupancy in range even if the caller misbehaves.
  assign do_push = push && !flush && (count_q != CW'(DEPTH));
  assign do_pop  = pop && !flush && (count_q != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

  assign rdata = mem[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential PC generation feeding a decoupling queue,
// with redirect flushing the queue and reloading the fetch PC.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned   DEPTH    = 4,
  parameter int unsigned   IW       = 32,
  parameter int unsigned   AW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(FqResetPc)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect,
  input  logic [AW-1:0]           redirect_pc,
  output logic [AW-1:0]           im_addr,
  input  logic [IW-1:0]           im_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [AW-1:0]           out_pc,
  output logic [IW-1:0]           out_ins,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned CW = fq_cnt_w(DEPTH);

  logic [AW-1:0]    fpc_q;
  logic             push, pop;
  logic [AW+IW-1:0] rdata;

  // Push decision uses the pre-edge count, so a full queue being popped does not refill.
  assign push      = (count != CW'(DEPTH)) && !redirect;
  assign pop       = out_valid && out_ready && !redirect;
  assign out_valid = (count != '0);
  assign im_addr   = fpc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc_q <= RESET_PC;
    end else if (redirect) begin
      fpc_q <= redirect_pc;
    end else if (push) begin
      fpc_q <= fpc_q + AW'(FqPcInc);
    end
  end

  fq_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(AW + IW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(redirect),
    .push (push),
    .pop  (pop),
    .wdata({fpc_q, im_data}),
    .rdata(rdata),
    .count(count)
  );

  assign out_pc  = rdata[IW +: AW];
  assign out_ins = rdata[IW-1:0];

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning queue entries; the block SHALL accept powers of two from 2 to 16.
REQ-002 Parameter IW, default 32, meaning instruction width.
REQ-003 Parameter AW, default 32, meaning PC width.
REQ-004 Parameter RESET_PC, default 0, meaning PC after reset.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port redirect, input, 1 bit: branch/jump redirect request.
REQ-008 Port redirect_pc, input, AW bits: redirect target.
REQ-009 Port im_addr, output, AW bits: instruction-memory address, equal to the fetch PC.
REQ-010 Port im_data, input, IW bits: combinational instruction-memory read data for im_addr.
REQ-011 Port out_valid, output, 1 bit: head entry valid.
REQ-012 Port out_ready, input, 1 bit: decoder accepts the head entry.
REQ-013 Port out_pc, output, AW bits: PC of the head entry.
REQ-014 Port out_ins, output, IW bits: instruction of the head entry.
REQ-015 Port count, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-016 Fetch PC register fpc: a push SHALL occur on any cycle with count<DEPTH and redirect=0, storing {fpc, im_data} at the tail and setting fpc to fpc+4 modulo 2^AW.
REQ-017 A pop SHALL occur when out_valid and out_ready are both 1; the head then advances.
REQ-018 out_valid SHALL equal (count!=0); out_pc and out_ins SHALL come from the head entry (first-word fall-through, zero extra latency).
REQ-019 A push and pop in the same cycle SHALL leave count unchanged; the full-and-pop case SHALL NOT push, because the push decision uses the pre-edge count.
REQ-020 Read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-021 redirect=1 SHALL, at the next edge, clear all entries (count=0, pointers=0), load fpc with redirect_pc, and suppress that cycle's push and pop.
REQ-022 Redirect SHALL take priority over simultaneous push and pop.
REQ-023 While out_valid=0, out_ready SHALL be ignored.
REQ-024 Latency: an instruction present on im_data at edge N SHALL be visible on out_ins after edge N when the queue was empty.
REQ-025 Back-to-back redirects SHALL each reload fpc, with no push between them.
REQ-026 Payload of invalid entries is don't-care; out_pc/out_ins SHALL NOT be relied on while out_valid=0.

Reset
REQ-027 While rst=0, the block SHALL asynchronously force fpc=RESET_PC, count=0 and both pointers=0, so out_valid=0.
REQ-028 Entry storage SHALL NOT require reset.
REQ-029 Reset deassertion mid-operation SHALL restart fetching at RESET_PC; no pre-reset entry SHALL emerge.

Structure
REQ-030 RESET_PC default and the PC increment constant (4) SHALL live in the shared define header used by the control encodings.
REQ-031 Storage and pointer logic SHALL be one sub-module, fq_fifo (parameters DEPTH and width AW+IW, with flush input); PC generation and push policy SHALL stay in fetch_queue.

Verification
REQ-032 Reset, then out_ready=0 for 6 cycles -> count reaches 4 and stops; im_addr holds 0x10; out_pc=0x0.
REQ-033 Full queue, then out_ready=1 continuously -> one pop per cycle; out_pc sequence is 0x0, 0x4, 0x8, ...; count stays 4 minus 1 while streaming (push/pop balance); no duplicates or gaps.
REQ-034 redirect=1 with redirect_pc=0x40 while count=3 and out_ready=1 -> next cycle count=0 and im_addr=0x40; the following cycle out_pc=0x40.
REQ-035 Redirect on two consecutive cycles (0x80, then 0xC0) -> only 0xC0 is fetched; no entry with PC 0x80 appears.
REQ-036 Assert rst=0 asynchronously mid-stream with count=2 -> out_valid falls immediately without a clock edge; after release the first out_pc is RESET_PC.
REQ-037 Repeat REQ-032 and REQ-033 with DEPTH=2 and DEPTH=16 -> pointer wrap is correct and count saturates at DEPTH.
